// File: rtl/nbit_reg_write_arbiter.sv
// Round-robin owner of one shared n-bit register among 4 requesters; grant 1 cycle after req, first write 1 cycle after grant.
// No backpressure: a grantee writes every cycle it holds req, bursts capped at MAX_BURST, one idle cycle between grants.
module nbit_reg_write_arbiter #(
  parameter int n         = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [4*n-1:0]   wdata,
  output logic [3:0]       gnt,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             upd,
  output logic [n-1:0]     out0
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LastBeat = 8'(MAX_BURST - 1);

  state_t     state;
  logic [7:0] burst_cnt;
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;

  // Scan starting just after the previous owner so the last grantee has lowest priority.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      upd       <= 1'b0;
      out0      <= '0;
      burst_cnt <= '0;
      last      <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          upd <= 1'b0;
          if (|req) begin
            state     <= GRANT;
            gnt       <= 4'b0001 << winner;
            owner     <= winner;
            busy      <= 1'b1;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (req[owner]) begin
            out0 <= wdata[owner*n +: n];
            upd  <= 1'b1;
          end else begin
            upd  <= 1'b0;
          end
          // Release after the final beat of a full burst, or as soon as the owner drops req.
          if (!req[owner] || burst_cnt == LastBeat) begin
            state     <= IDLE;
            last      <= owner;
            gnt       <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_reg_write_arbiter.sv
// Directed bench for nbit_reg_write_arbiter: per-cycle vector table plus hand sequences for isolation and mid-burst reset.
module tb_nbit_reg_write_arbiter;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req = 4'hF;
  logic [4*N-1:0] wdata = '0;
  logic [3:0]     gnt;
  logic [1:0]     owner;
  logic           busy;
  logic           upd;
  logic [N-1:0]   out0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] wd;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        upd;
    logic [15:0] out0;
  } vec_t;

  vec_t vq[$];

  nbit_reg_write_arbiter #(.n(N), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .upd   (upd),
    .out0  (out0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] o,
                            input logic b, input logic u, input logic [15:0] d);
    chk({tag, ".gnt"},   32'(gnt),   32'(g));
    chk({tag, ".owner"}, 32'(owner), 32'(o));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".upd"},   32'(upd),   32'(u));
    chk({tag, ".out0"},  32'(out0),  32'(d));
  endtask

  task automatic add(input logic [3:0] r, input logic [63:0] wd, input logic [3:0] g,
                     input logic [1:0] o, input logic b, input logic u, input logic [15:0] d);
    vec_t v;
    v.req = r; v.wd = wd; v.gnt = g; v.owner = o; v.busy = b; v.upd = u; v.out0 = d;
    vq.push_back(v);
  endtask

  // One full burst: grant edge, three writes while granted, fourth write coinciding with release.
  task automatic add_grant(input logic [3:0] r, input logic [63:0] wd, input logic [1:0] o,
                           input logic [15:0] prev);
    logic [15:0] v;
    v = wd[o*16 +: 16];
    add(r, wd, 4'b0001 << o, o, 1'b1, 1'b0, prev);
    for (int b = 0; b < 3; b++) add(r, wd, 4'b0001 << o, o, 1'b1, 1'b1, v);
    add(r, wd, 4'b0000, o, 1'b0, 1'b1, v);
  endtask

  initial begin
    logic [63:0] wd3, wd2, wd4;
    logic [15:0] prev;
    logic [1:0]  o;

    wd3 = 64'h1003_1002_1001_1000;
    wd2 = 64'h0000_00A5_0000_0000;
    wd4 = 64'h0000_0000_BEEF_0000;

    // Idle after reset
    add(4'h0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000);
    add(4'h0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000);
    // All requesting: owners 0,1,2,3,0
    prev = 16'h0000;
    for (int g = 0; g < 5; g++) begin
      o = 2'(g % 4);
      add_grant(4'hF, wd3, o, prev);
      prev = 16'h1000 + 16'(o);
    end
    add(4'h0, wd3, 4'h0, 2'd0, 1'b0, 1'b0, 16'h1000);
    // Single requester 2, three writes then drop
    add(4'b0100, wd2, 4'b0100, 2'd2, 1'b1, 1'b0, 16'h1000);
    for (int b = 0; b < 3; b++) add(4'b0100, wd2, 4'b0100, 2'd2, 1'b1, 1'b1, 16'h00A5);
    add(4'h0, wd2, 4'h0, 2'd2, 1'b0, 1'b0, 16'h00A5);
    add(4'h0, wd2, 4'h0, 2'd2, 1'b0, 1'b0, 16'h00A5);
    // Requester 1 alone: capped burst, idle, regrant
    add_grant(4'b0010, wd4, 2'd1, 16'h00A5);
    add_grant(4'b0010, wd4, 2'd1, 16'hBEEF);
    add(4'h0, wd4, 4'h0, 2'd1, 1'b0, 1'b0, 16'hBEEF);

    // Reset held with all requests active
    repeat (2) @(posedge clk);
    #1 check_outs("t1_rst", 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'h0;

    foreach (vq[i]) begin
      @(negedge clk);
      req   = vq[i].req;
      wdata = vq[i].wd;
      @(posedge clk);
      #1 check_outs($sformatf("vec%0d", i), vq[i].gnt, vq[i].owner, vq[i].busy, vq[i].upd, vq[i].out0);
    end

    // Isolation: requester 0 presents 16'hDEAD while 1 owns the register
    @(negedge clk);
    req   = 4'b0010;
    wdata = {16'h0000, 16'h0000, 16'h1111, 16'hDEAD};
    @(posedge clk);
    #1 chk("t5_gnt", 32'(gnt), 32'h2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req = 4'b0011;
      @(posedge clk);
      #1;
      chk($sformatf("t5_out0_%0d", k), 32'(out0), 32'h1111);
      chk($sformatf("t5_notdead_%0d", k), 32'(out0 != 16'hDEAD), 32'h1);
    end
    @(negedge clk);
    req = 4'h0;
    @(posedge clk);
    #1 chk("t5_hold", 32'(out0), 32'h1111);

    // Asynchronous reset in the middle of a burst by requester 2
    @(negedge clk);
    req   = 4'b0100;
    wdata = {16'h0000, 16'h2222, 16'h0000, 16'h0000};
    @(posedge clk);
    #1 chk("t6_gnt", 32'(gnt), 32'h4);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_out0", 32'(out0), 32'h2222);
    chk("t6_upd", 32'(upd), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_outs("t6_rst", 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'hF;
    @(posedge clk);
    #1;
    chk("t6_regnt", 32'(gnt), 32'h1);
    chk("t6_owner", 32'(owner), 32'h0);
    chk("t6_busy", 32'(busy), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
